pipe_reg_chain: RTL and testbench

//  Parametrised multi-stage pipeline register with valid/ready flow control, replacing the

---
 rtl/pipe_reg_chain_if.sv | 21 ++
 rtl/pipe_reg_chain.sv | 141 ++++++++++++++
 tb/tb_pipe_reg_chain.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if
//   Valid/ready/data handshake bundle used on both sides of pipe_reg_chain.
//   Parameter:
//     WIDTH  payload width in bits
//   Signals:
//     valid  source has a payload on data
//     ready  sink accepts data this cycle
//     data   payload
//   Modports:
//     master  drives valid/data, observes ready (the sending side)
//     slave   observes valid/data, drives ready (the receiving side)
interface pipe_reg_chain_if #(
  parameter int WIDTH = 103
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Multi-stage pipeline register with valid/ready flow control. Carries an
//   opaque WIDTH-bit payload through DEPTH register stages. Ready ripples
//   combinationally from the output side, so empty stages (bubbles) are
//   squeezed out while the output is stalled. flush_i kills every in-flight
//   entry; rst has priority over flush_i, flush_i over normal advance.
//   Parameters:
//     WIDTH       payload width in bits
//     DEPTH       number of register stages (>= 1)
//     RESET_DATA  payload value loaded into every stage on reset
//   Ports:
//     clk      clock, rising edge
//     rst      synchronous reset, active-high
//     flush_i  discard all in-flight entries at the next edge
//     in_i     producer side (slave): valid/data in, ready out (combinational)
//     out_o    consumer side (master): valid/data out (registered), ready in
//     busy_o   OR of all stage valid bits
//     occ_o    count of valid stages (only when PIPE_OCC_EN is defined)
//   Configuration macro:
//     PIPE_OCC_EN  adds the registered occupancy counter and port occ_o
module pipe_reg_chain #(
  parameter int              WIDTH      = 103,
  parameter int              DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  pipe_reg_chain_if.slave   in_i,
  pipe_reg_chain_if.master  out_o,
  output logic              busy_o
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
`endif
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] go_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  // Advance terms: a stage may load when anything downstream can make room.
  always_comb begin : p_go
    logic ripple;
    ripple = out_o.ready;
    go_s   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ripple  = ripple | ~v_q[k];
      go_s[k] = ripple;
    end
  end

  assign in_i.ready  = go_s[0] & ~flush_i & ~rst;
  assign in_xfer_s   = in_i.valid & in_i.ready;
  assign out_xfer_s  = v_q[DEPTH-1] & out_o.ready;
  assign out_o.valid = v_q[DEPTH-1];
  assign out_o.data  = d_q[DEPTH-1];
  assign busy_o      = |v_q;

  // Next-state for valid bits and payloads; payload only written when a valid entry moves in.
  always_comb begin
    v_d = v_q;
    for (int k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
    end
    if (flush_i) begin
      // Payloads are left untouched so out_o.data does not toggle.
      v_d = '0;
    end else begin
      if (go_s[0]) begin
        v_d[0] = in_xfer_s;
        if (in_xfer_s) begin
          d_d[0] = in_i.data;
        end else begin
          d_d[0] = d_q[0];
        end
      end else begin
        v_d[0] = v_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (go_s[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            d_d[k] = d_q[k-1];
          end else begin
            d_d[k] = d_q[k];
          end
        end else begin
          v_d[k] = v_q[k];
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_DATA;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

`ifdef PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;

  // Occupancy counter tracking the popcount of the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (flush_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer_s) - OCC_W'(out_xfer_s);
    end
  end

  assign occ_o = occ_q;
`else
  // Output transfer only feeds the occupancy counter.
  logic unused_s;
  assign unused_s = out_xfer_s;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain
//   Directed bench for pipe_reg_chain: a WIDTH=8/DEPTH=3 instance for reset,
//   streaming, backpressure, bubble collapse and flush, plus a
//   WIDTH=103/DEPTH=1 instance for back-to-back traffic. A randomised phase
//   drives both instances against reference queues.
`timescale 1ns/1ps
module tb_pipe_reg_chain;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy3;
  logic busy1;
`ifdef PIPE_OCC_EN
  logic [1:0] occ3;
  logic [0:0] occ1;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  pipe_reg_chain_if #(.WIDTH(8))   a_in ();
  pipe_reg_chain_if #(.WIDTH(8))   a_out ();
  pipe_reg_chain_if #(.WIDTH(103)) b_in ();
  pipe_reg_chain_if #(.WIDTH(103)) b_out ();

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_DATA(8'h00)) u_dut3 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_i(a_in), .out_o(a_out), .busy_o(busy3)
`ifdef PIPE_OCC_EN
    , .occ_o(occ3)
`endif
  );

  pipe_reg_chain #(.WIDTH(103), .DEPTH(1), .RESET_DATA(103'd0)) u_dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_i(b_in), .out_o(b_out), .busy_o(busy1)
`ifdef PIPE_OCC_EN
    , .occ_o(occ1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    a_in.valid = 1'b0; a_in.data = 8'h00; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = 103'd0; b_out.ready = 1'b0;
    tick();
    n_tests++; if (a_in.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got %b want 0", a_in.ready); end
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (a_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out.valid); end
    n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy3); end
    n_tests++; if (a_out.data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", a_out.data); end
    n_tests++; if (a_in.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a_in.ready); end
    n_tests++; if (b_out.valid !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_d1 got valid=%b busy=%b want 0/0", b_out.valid, busy1); end
`ifdef PIPE_OCC_EN
    n_tests++; if (occ3 !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ3); end
`endif
  endtask

  task automatic test_streaming();
    logic       ev;
    logic [7:0] ed;
    a_out.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        a_in.valid = 1'b1;
        a_in.data  = 8'(8'h11 * (i + 1));
        #1;
        n_tests++; if (a_in.ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, a_in.ready); end
      end else begin
        a_in.valid = 1'b0;
      end
      tick();
      ev = (i >= 2 && i <= 4);
      ed = 8'(8'h11 * (i - 1));
      n_tests++; if (a_out.valid !== ev) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want %b", i, a_out.valid, ev); end
      if (ev) begin
        n_tests++; if (a_out.data !== ed) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, a_out.data, ed); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] items [5];
    int acc;
    items = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    acc = 0;
    a_out.ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_in.valid = 1'b1;
      a_in.data  = items[acc];
      #1;
      n_tests++; if (a_in.ready !== ((c < 3) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL bp_fill_ready[%0d] got %b want %b", c, a_in.ready, (c < 3)); end
      tick();
      if (c < 3) acc++;
    end
    n_tests++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h01) begin n_fail++; $display("FAIL bp_hold got valid=%b data=%h want 1/01", a_out.valid, a_out.data); end
    a_out.ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (acc < 5) begin
        a_in.valid = 1'b1;
        a_in.data  = items[acc];
      end else begin
        a_in.valid = 1'b0;
      end
      #1;
      n_tests++; if (a_out.valid !== 1'b1 || a_out.data !== items[j]) begin n_fail++; $display("FAIL bp_drain[%0d] got valid=%b data=%h want 1/%h", j, a_out.valid, a_out.data, items[j]); end
      if (acc < 5) begin
        n_tests++; if (a_in.ready !== 1'b1) begin n_fail++; $display("FAIL bp_refill_ready[%0d] got %b want 1", j, a_in.ready); end
        acc++;
      end
      tick();
    end
    n_tests++; if (a_out.valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", a_out.valid); end
  endtask

  task automatic test_bubble();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 8'hA0;
    tick();
    a_in.valid = 1'b0;
    tick();
    a_in.valid = 1'b1; a_in.data = 8'hB0;
    #1;
    n_tests++; if (a_in.ready !== 1'b1) begin n_fail++; $display("FAIL bubble_in_ready got %b want 1", a_in.ready); end
    tick();
    a_in.valid = 1'b0;
    tick();
    n_tests++; if (a_out.valid !== 1'b1 || a_out.data !== 8'hA0 || busy3 !== 1'b1) begin n_fail++; $display("FAIL bubble_held got valid=%b data=%h busy=%b want 1/a0/1", a_out.valid, a_out.data, busy3); end
    tick();
    n_tests++; if (a_out.data !== 8'hA0) begin n_fail++; $display("FAIL bubble_stable got %h want a0", a_out.data); end
    a_out.ready = 1'b1;
    tick();
    n_tests++; if (a_out.valid !== 1'b1 || a_out.data !== 8'hB0) begin n_fail++; $display("FAIL bubble_second got valid=%b data=%h want 1/b0", a_out.valid, a_out.data); end
    tick();
    n_tests++; if (a_out.valid !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL bubble_drained got valid=%b busy=%b want 0/0", a_out.valid, busy3); end
  endtask

  task automatic test_flush();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 8'h51;
    tick();
    a_in.data = 8'h52;
    tick();
    flush = 1'b1; a_in.data = 8'hEE;
    #1;
    n_tests++; if (a_in.ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", a_in.ready); end
    tick();
    flush = 1'b0; a_in.valid = 1'b0;
    n_tests++; if (busy3 !== 1'b0 || a_out.valid !== 1'b0) begin n_fail++; $display("FAIL flush_cleared got busy=%b valid=%b want 0/0", busy3, a_out.valid); end
    n_tests++; if (a_out.data !== 8'hB0) begin n_fail++; $display("FAIL flush_data_kept got %h want b0", a_out.data); end
`ifdef PIPE_OCC_EN
    n_tests++; if (occ3 !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occ3); end
`endif
    a_out.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (a_out.valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emerge[%0d] got %b want 0", i, a_out.valid); end
    end
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 8'h61;
    tick();
    a_in.data = 8'h62;
    tick();
    a_in.valid = 1'b0;
    tick();
    n_tests++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h61) begin n_fail++; $display("FAIL rstflush_pre got valid=%b data=%h want 1/61", a_out.valid, a_out.data); end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    n_tests++; if (a_out.valid !== 1'b0 || busy3 !== 1'b0 || a_out.data !== 8'h00 || a_in.ready !== 1'b1) begin n_fail++; $display("FAIL rstflush_post got valid=%b busy=%b data=%h rdy=%b want 0/0/00/1", a_out.valid, busy3, a_out.data, a_in.ready); end
  endtask

  task automatic test_depth1();
    logic [102:0] val;
    logic [102:0] prev;
    prev = 103'd0;
    b_out.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      val = {3'(i + 1), 100'd0} | 103'(32'hC0FFEE00 + i);
      b_in.valid = 1'b1;
      b_in.data  = val;
      #1;
      n_tests++; if (b_in.ready !== 1'b1) begin n_fail++; $display("FAIL d1_in_ready[%0d] got %b want 1", i, b_in.ready); end
      n_tests++; if (b_out.valid !== (i > 0)) begin n_fail++; $display("FAIL d1_valid[%0d] got %b want %b", i, b_out.valid, (i > 0)); end
      if (i > 0) begin
        n_tests++; if (b_out.data !== prev) begin n_fail++; $display("FAIL d1_data[%0d] got %h want %h", i, b_out.data, prev); end
      end
      prev = val;
      tick();
    end
    b_in.valid = 1'b0;
    n_tests++; if (b_out.valid !== 1'b1 || b_out.data !== prev) begin n_fail++; $display("FAIL d1_last got valid=%b data=%h want 1/%h", b_out.valid, b_out.data, prev); end
    tick();
    n_tests++; if (b_out.valid !== 1'b0) begin n_fail++; $display("FAIL d1_empty got %b want 0", b_out.valid); end
  endtask

  task automatic test_random();
    logic [7:0]   qa [$];
    logic [102:0] qb [$];
    logic         er_a;
    logic         er_b;
    for (int c = 0; c < 2000; c++) begin
      if (c < 1992) begin
        a_in.valid  = 1'($urandom_range(0, 1));
        a_in.data   = 8'($urandom);
        a_out.ready = ($urandom_range(0, 2) != 0);
        b_in.valid  = 1'($urandom_range(0, 1));
        b_in.data   = 103'({$urandom, $urandom, $urandom, $urandom});
        b_out.ready = ($urandom_range(0, 2) != 0);
        flush       = ($urandom_range(0, 40) == 0);
      end else begin
        a_in.valid = 1'b0; b_in.valid = 1'b0;
        a_out.ready = 1'b1; b_out.ready = 1'b1; flush = 1'b0;
      end
      #1;
      er_a = ~flush & (a_out.ready | (qa.size() < 3));
      er_b = ~flush & (b_out.ready | (qb.size() == 0));
      n_tests++; if (a_in.ready !== er_a) begin n_fail++; $display("FAIL rnd_a_ready[%0d] got %b want %b", c, a_in.ready, er_a); end
      n_tests++; if (busy3 !== (qa.size() != 0)) begin n_fail++; $display("FAIL rnd_a_busy[%0d] got %b want %b", c, busy3, (qa.size() != 0)); end
      if (qa.size() == 0) begin
        n_tests++; if (a_out.valid !== 1'b0) begin n_fail++; $display("FAIL rnd_a_valid[%0d] got %b want 0", c, a_out.valid); end
      end else if (a_out.valid === 1'b1) begin
        n_tests++; if (a_out.data !== qa[0]) begin n_fail++; $display("FAIL rnd_a_data[%0d] got %h want %h", c, a_out.data, qa[0]); end
      end
      n_tests++; if (b_in.ready !== er_b) begin n_fail++; $display("FAIL rnd_b_ready[%0d] got %b want %b", c, b_in.ready, er_b); end
      n_tests++; if (b_out.valid !== (qb.size() != 0)) begin n_fail++; $display("FAIL rnd_b_valid[%0d] got %b want %b", c, b_out.valid, (qb.size() != 0)); end
      if (qb.size() != 0) begin
        n_tests++; if (b_out.data !== qb[0]) begin n_fail++; $display("FAIL rnd_b_data[%0d] got %h want %h", c, b_out.data, qb[0]); end
      end
`ifdef PIPE_OCC_EN
      n_tests++; if (occ3 !== 2'(qa.size()) || occ1 !== 1'(qb.size())) begin n_fail++; $display("FAIL rnd_occ[%0d] got %0d/%0d want %0d/%0d", c, occ3, occ1, qa.size(), qb.size()); end
`endif
      if (a_out.valid === 1'b1 && a_out.ready && qa.size() != 0) void'(qa.pop_front());
      if (a_in.valid && er_a) qa.push_back(a_in.data);
      if (b_out.valid === 1'b1 && b_out.ready && qb.size() != 0) void'(qb.pop_front());
      if (b_in.valid && er_b) qb.push_back(b_in.data);
      if (flush) begin
        qa.delete();
        qb.delete();
      end
      tick();
    end
    n_tests++; if (qa.size() != 0 || qb.size() != 0 || busy3 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got left=%0d/%0d busy=%b/%b want 0/0 0/0", qa.size(), qb.size(), busy3, busy1); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_depth1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
